// File: rtl/seg7_pkg.sv
// Shared types and helpers for the seven-segment receive monitor.
// Segment bus order is {g,f,e,d,c,b,a}, active high.
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;

  typedef enum logic [1:0] {
    IDLE,
    FIRST,
    TRACK
  } state_t;

  typedef struct packed {
    logic       legal;
    logic [3:0] digit;
  } seg_dec_t;

  // Blank is reported as not legal; callers filter it separately.
  function automatic seg_dec_t seg_to_digit(
    input logic [6:0] seg
  );
    seg_dec_t r;
    r.legal = 1'b1;
    r.digit = 4'd0;
    case (seg)
      SEG_0: r.digit = 4'd0;
      SEG_1: r.digit = 4'd1;
      SEG_2: r.digit = 4'd2;
      SEG_3: r.digit = 4'd3;
      SEG_4: r.digit = 4'd4;
      SEG_5: r.digit = 4'd5;
      SEG_6: r.digit = 4'd6;
      SEG_7: r.digit = 4'd7;
      SEG_8: r.digit = 4'd8;
      SEG_9: r.digit = 4'd9;
      default: r.legal = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] next_digit(
    input logic [3:0] last,
    input logic       down
  );
    if (down)
      return (last == 4'd0) ? 4'd9 : last - 4'd1;
    return (last == 4'd9) ? 4'd0 : last + 4'd1;
  endfunction

endpackage

// File: rtl/seg7_if.sv
// Segment bus in, decoded digit / period / error status out.
// master = segment source and status consumer, slave = monitor.
interface seg7_if #(
  parameter int PERIOD_W = 24
);

  logic [6:0]          seg_in;
  logic                count_down;
  logic [3:0]          digit_out;
  logic                digit_valid;
  logic [PERIOD_W-1:0] period_out;
  logic                period_valid;
  logic                pattern_error;
  logic                seq_error;
  logic [7:0]          err_count;
  logic                locked;

  modport master (
    output seg_in,
    output count_down,
    input  digit_out,
    input  digit_valid,
    input  period_out,
    input  period_valid,
    input  pattern_error,
    input  seq_error,
    input  err_count,
    input  locked
  );

  modport slave (
    input  seg_in,
    input  count_down,
    output digit_out,
    output digit_valid,
    output period_out,
    output period_valid,
    output pattern_error,
    output seq_error,
    output err_count,
    output locked
  );

endinterface

// File: rtl/seg7_filter.sv
// Two-flop synchronizer plus stability filter on the segment bus.
// Emits a single accept pulse once a pattern has been stable long enough.
module seg7_filter #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] seg_in,
  output logic       accept,
  output logic [6:0] pattern
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] STAB_MAX = CW'(STABLE_CYCLES);

  logic [6:0]    s1;
  logic [6:0]    s2;
  logic [CW-1:0] stab_cnt;
  logic          taken;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1       <= '0;
      s2       <= '0;
      pattern  <= '0;
      stab_cnt <= '0;
      taken    <= 1'b0;
      accept   <= 1'b0;
    end else begin
      s1     <= seg_in;
      s2     <= s1;
      accept <= 1'b0;
      if (s2 != pattern) begin
        pattern  <= s2;
        stab_cnt <= '0;
        taken    <= 1'b0;
      end else if (stab_cnt != STAB_MAX) begin
        stab_cnt <= stab_cnt + 1'b1;
      end else if (!taken) begin
        accept <= 1'b1;
        taken  <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/seg7_monitor.sv
// Decodes filtered segment patterns, checks digit sequencing,
// measures digit period and tracks lock/error status.
module seg7_monitor
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int PERIOD_W      = 24,
  parameter int LOCK_COUNT    = 3
) (
  input logic   clk,
  input logic   reset,
  seg7_if.slave bus
);

  localparam int SW = $clog2(LOCK_COUNT + 1);
  localparam logic [SW-1:0] LOCK_MAX = SW'(LOCK_COUNT);

  logic                accept;
  logic [6:0]          pattern;

  state_t              state;
  logic [6:0]          last_pat;
  logic [3:0]          digit_q;
  logic                digit_valid_q;
  logic [PERIOD_W-1:0] per_cnt;
  logic [PERIOD_W-1:0] period_q;
  logic                period_valid_q;
  logic                pattern_error_q;
  logic                seq_error_q;
  logic [7:0]          err_count_q;
  logic [SW-1:0]       streak;
  logic                locked_q;

  seg_dec_t            dec;
  logic                dig_ev;
  logic                pat_ev;
  logic                hit;
  logic                err_ev;
  logic [3:0]          succ;
  logic [SW-1:0]       streak_nx;

  seg7_filter #(
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_filter (
    .clk    (clk),
    .reset  (reset),
    .seg_in (bus.seg_in),
    .accept (accept),
    .pattern(pattern)
  );

  always_comb begin
    dec    = seg_to_digit(pattern);
    pat_ev = accept && !dec.legal && (pattern != SEG_BLANK);
    // Re-accepting the last digit (e.g. after a glitch) is silent.
    dig_ev = accept && dec.legal && (pattern != last_pat);
    succ   = next_digit(digit_q, bus.count_down);
    hit    = (dec.digit == succ);
    err_ev = pat_ev || (dig_ev && (state != IDLE) && !hit);
    if (state == FIRST)
      streak_nx = SW'(1);
    else if (streak == LOCK_MAX)
      streak_nx = streak;
    else
      streak_nx = streak + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      last_pat        <= '0;
      digit_q         <= '0;
      digit_valid_q   <= 1'b0;
      per_cnt         <= '0;
      period_q        <= '0;
      period_valid_q  <= 1'b0;
      pattern_error_q <= 1'b0;
      seq_error_q     <= 1'b0;
      err_count_q     <= '0;
      streak          <= '0;
      locked_q        <= 1'b0;
    end else begin
      digit_valid_q   <= 1'b0;
      period_valid_q  <= 1'b0;
      pattern_error_q <= pat_ev;
      seq_error_q     <= 1'b0;
      if (per_cnt != '1)
        per_cnt <= per_cnt + 1'b1;
      if (err_ev && err_count_q != 8'hFF)
        err_count_q <= err_count_q + 8'd1;
      if (dig_ev) begin
        last_pat      <= pattern;
        digit_q       <= dec.digit;
        digit_valid_q <= 1'b1;
        per_cnt       <= PERIOD_W'(1);
        unique case (state)
          IDLE: begin
            state <= FIRST;
          end
          FIRST, TRACK: begin
            state          <= TRACK;
            period_valid_q <= 1'b1;
            period_q       <= per_cnt;
            if (hit) begin
              streak   <= streak_nx;
              locked_q <= (streak_nx == LOCK_MAX);
            end else begin
              seq_error_q <= 1'b1;
              streak      <= '0;
              locked_q    <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.digit_out     = digit_q;
  assign bus.digit_valid   = digit_valid_q;
  assign bus.period_out    = period_q;
  assign bus.period_valid  = period_valid_q;
  assign bus.pattern_error = pattern_error_q;
  assign bus.seq_error     = seq_error_q;
  assign bus.err_count     = err_count_q;
  assign bus.locked        = locked_q;

endmodule
